imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Byte-stream program loader for the 8-bit pipelined processor.
- Accepts a length-prefixed, checksummed program over a valid/ready byte interface and writes it into the core's instruction memory starting at address 0.
- Holds the core in reset until a load completes with a correct checksum.
- Sits between the host/bench stimulus side and the P_Pipe core; it is the supply end of the core's instruction-fetch path.

Parameters:
- ADDR_W, 5, instruction-memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word and stream byte width; fixed at 8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  restart request; single-cycle pulse.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  instruction-memory write address.
- imem_wdata  out  8  instruction-memory write data.
- core_rst  out  1  active-high reset to the core; 1 = core held.
- done  out  1  program loaded and verified; core running.
- err  out  1  load failed (bad length or checksum).

Behaviour:
- Reset (reset=0, async):
  - State = LEN; addr counter = 0; remaining count = 0; checksum accumulator = 0.
  - Outputs: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0.
- Stream format: LEN byte N, then N data bytes, then CSUM byte.
  - Valid only if (N + sum(data) + CSUM) mod 256 == 0.
- Handshake: a byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = 1 in LEN, DATA and CSUM, and start=0. Otherwise 0 (combinational on start).
  - in_data may change freely when in_valid=0.
- States:
  - LEN: on transfer, N==0 or N>DEPTH -> ERR. Otherwise load remaining=N, acc=N -> DATA.
  - DATA: on transfer, acc += byte (mod 256) and schedule a write. remaining-1. When remaining reaches 0 -> CSUM.
  - CSUM: on transfer, (acc + byte) mod 256 == 0 -> RUN, else -> ERR.
  - RUN: done=1, core_rst=0, in_ready=0.
  - ERR: err=1, core_rst=1, in_ready=0.
- Write timing (registered):
  - A DATA byte accepted at edge k produces imem_we=1, imem_addr=current addr, imem_wdata=byte during the cycle after edge k.
  - imem_we=0 in every other cycle.
  - addr increments after each write and wraps mod DEPTH. N<=DEPTH, so no overwrite.
- Back-to-back transfers are allowed every cycle; the loader never stalls in LEN/DATA/CSUM.
- core_rst falls and done rises in the cycle after the accepted CSUM edge, aligned with the last write having already completed.
- start=1 in any state (priority over any byte):
  - Next state = LEN; addr=0; acc=0.
  - done=0, err=0, core_rst=1 next cycle.
  - imem_we=0 next cycle; a write that was pending is dropped.
- in_valid while in_ready=0 is ignored; no byte is consumed.
- Async reset mid-load aborts immediately. Memory contents are undefined; core_rst=1.

Test Plan:
- Good load: stream 0x03,0x11,0x22,0x33,0x97 on consecutive cycles.
  - Required: writes (0,0x11),(1,0x22),(2,0x33), one per cycle.
  - Then done=1, core_rst=0, err=0, in_ready=0.
- Bad checksum: same stream with CSUM=0x98.
  - Required: three writes occur; err=1, core_rst=1, done=0.
- Bad length: LEN=0x00, then separately LEN=DEPTH+1=0x21.
  - Required: ERR after the LEN byte each time; no imem_we ever asserted.
- Gapped valid / restart: in_valid toggled 1,0,1 through a good load.
  - Required: writes only on accepted bytes.
  - Then start pulse in RUN -> done=0, core_rst=1, addr restarts at 0 on next load.
- Start during DATA with in_valid=1 on the same cycle.
  - Required: in_ready=0, byte dropped, state LEN.
  - A following full good stream loads correctly.
- Full depth: N=32 with bytes 0x00..0x1F and the correct CSUM.
  - Required: addresses 0..31 are written; done=1.
- Async reset asserted mid-DATA.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Stream-in and instruction-memory write bus of the boot loader.
// The host/bench side drives the stream as master; the loader is the slave.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Length-prefixed, checksummed program loader for the core's instruction memory.
// Keeps the core in reset until a load verifies, then releases it.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst,
  output logic                done,
  output logic                err
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_sum;
  logic              accepting;
  logic              xfer;
  logic              len_bad;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_d, err_d, core_rst_d;

  // Ready depends on start combinationally so a restart always wins over a byte
  assign accepting    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign bus.in_ready = accepting && !start;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign acc_sum      = acc_q + bus.in_data;
  assign len_bad      = (bus.in_data == '0) || (32'(bus.in_data) > DEPTH);

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;

  // State register plus registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LEN;
      done     <= 1'b0;
      err      <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      err      <= err_d;
      core_rst <= core_rst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LEN;
    end else if (xfer) begin
      unique case (state_q)
        S_LEN:   state_d = len_bad ? S_ERR : S_DATA;
        S_DATA:  if (remaining_q == CNT_W'(1)) state_d = S_CSUM;
        S_CSUM:  state_d = (acc_sum == '0) ? S_RUN : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs follow the state being entered
  always_comb begin
    done_d     = 1'b0;
    err_d      = 1'b0;
    core_rst_d = 1'b1;
    if (state_d == S_RUN) begin
      done_d     = 1'b1;
      core_rst_d = 1'b0;
    end
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Datapath: length counter, checksum accumulator and one-cycle write pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else if (start) begin
      addr_q      <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          S_LEN: begin
            remaining_q <= CNT_W'(bus.in_data);
            acc_q       <= bus.in_data;
          end
          S_DATA: begin
            acc_q       <= acc_sum;
            remaining_q <= remaining_q - CNT_W'(1);
            we_q        <= 1'b1;
            waddr_q     <= addr_q;
            wdata_q     <= bus.in_data;
            addr_q      <= addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench for imem_boot_loader: expected writes are queued as
// data bytes are driven and retired as the loader writes them.
module tb_imem_boot_loader;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic core_rst, done, err;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W-1:0] addr_m;
  logic [7:0]        stream_q[$];

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retire expected writes as the loader emits them
  always @(negedge clk) begin
    logic [ADDR_W+7:0] e;
    if (reset === 1'b1 && bus.imem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bus.imem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e[ADDR_W+7:8]));
        check("wr_data", 32'(bus.imem_wdata), 32'(e[7:0]));
      end
    end
  end

  // Drive one byte for exactly one edge; returns at posedge+1
  task automatic drive(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic build(input logic [7:0] n, input logic [7:0] first,
                       input logic [7:0] step, input logic [7:0] csum_delta);
    logic [7:0] s;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(n);
    s = n;
    b = first;
    for (int i = 0; i < int'(n); i++) begin
      stream_q.push_back(b);
      s = s + b;
      b = b + step;
    end
    stream_q.push_back(8'(32'd0 - 32'(s) + 32'(csum_delta)));
  endtask

  task automatic play(input bit gap);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (i > 0 && i < stream_q.size() - 1) begin
        exp_q.push_back({addr_m, stream_q[i]});
        addr_m = addr_m + ADDR_W'(1);
      end
      drive(stream_q[i]);
      if (gap && i < stream_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic status(input string tag, input logic d, input logic e,
                        input logic cr, input logic rdy);
    @(negedge clk);
    check({tag, "_done"},     32'(done),         32'(d));
    check({tag, "_err"},      32'(err),          32'(e));
    check({tag, "_core_rst"}, 32'(core_rst),     32'(cr));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(rdy));
    check({tag, "_wr_left"},  32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    check("ready_in_start", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    start  = 1'b0;
    addr_m = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    addr_m       = '0;
    #12;
    check("rst_we",       32'(bus.imem_we),    32'd0);
    check("rst_addr",     32'(bus.imem_addr),  32'd0);
    check("rst_wdata",    32'(bus.imem_wdata), 32'd0);
    check("rst_core_rst", 32'(core_rst),       32'd1);
    check("rst_done",     32'(done),           32'd0);
    check("rst_err",      32'(err),            32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Good load on consecutive cycles
    build(8'h03, 8'h11, 8'h11, 8'h00);
    check("good_csum_byte", 32'(stream_q[4]), 32'h97);
    play(1'b0);
    status("good", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad checksum: writes still happen, then ERR
    pulse_start();
    status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    build(8'h03, 8'h11, 8'h11, 8'h01);
    play(1'b0);
    status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0);

    // Bad lengths
    pulse_start();
    drive(8'h00);
    status("len_zero", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    drive(8'h21);
    status("len_big", 1'b0, 1'b1, 1'b1, 1'b0);

    // Gapped valid, ignored bytes in RUN, restart from RUN
    pulse_start();
    build(8'h04, 8'h5A, 8'h03, 8'h00);
    play(1'b1);
    status("gapped", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    status("run_ignore", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    status("start_in_run", 1'b0, 1'b0, 1'b1, 1'b1);
    build(8'h02, 8'hC3, 8'h10, 8'h00);
    play(1'b0);
    status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    // Start during DATA with a valid byte on the same cycle
    pulse_start();
    drive(8'h03);
    exp_q.push_back({ADDR_W'(0), 8'h11});
    addr_m = ADDR_W'(1);
    drive(8'h11);
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    @(negedge clk);
    check("ready_start_data", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    addr_m       = '0;
    @(negedge clk);
    check("drop_we", 32'(bus.imem_we), 32'd0);
    check("drop_ready_len", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    build(8'h03, 8'h11, 8'h11, 8'h00);
    play(1'b0);
    status("after_drop", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full depth
    pulse_start();
    build(8'h20, 8'h00, 8'h01, 8'h00);
    check("full_csum_byte", 32'(stream_q[33]), 32'hF0);
    play(1'b0);
    status("full", 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset mid-DATA
    pulse_start();
    build(8'h05, 8'hA1, 8'h11, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        exp_q.push_back({addr_m, stream_q[i]});
        addr_m = addr_m + ADDR_W'(1);
      end
      drive(stream_q[i]);
    end
    #2;
    reset = 1'b0;
    #1;
    check("arst_we",       32'(bus.imem_we),    32'd0);
    check("arst_addr",     32'(bus.imem_addr),  32'd0);
    check("arst_wdata",    32'(bus.imem_wdata), 32'd0);
    check("arst_core_rst", 32'(core_rst),       32'd1);
    check("arst_done",     32'(done),           32'd0);
    check("arst_err",      32'(err),            32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    addr_m = '0;
    build(8'h04, 8'h07, 8'h29, 8'h00);
    play(1'b0);
    status("post_arst", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
